frq_div_mod: RTL and testbench
==============================

// Module: frq_div_mod
// PURPOSE
//  Integer clock-frequency divider with a built-in rising-edge strobe generator.
//  - Derives a low-rate square wave (signal_out) from the system clock.
//  - Emits a one-clock pulse (strobe_out) at each rising edge of that wave, for clk-domain tick logic.
//  - Instantiated once per tick rate, e.g. DIV=20/30/40 from the 50 MHz system clock.
// PARAMETERS
//  DIV    20                 clk cycles per signal_out period; integer >= 2, elaboration error otherwise
//  CNT_W  $clog2(DIV) (>=1)  counter width; derived, do not override
// PORTS
//  clk         in   1  system clock; all logic on rising edge
//  rst         in   1  reset, asynchronous, active-high
//  en          in   1  count enable; 0 freezes the divider
//  signal_out  out  1  divided square wave, registered
//  strobe_out  out  1  one-clk pulse on each 0->1 of signal_out
// BEHAVIOUR
//  Reset state (async on rst=1; holds while rst=1):
//  - cnt=0, signal_out=0, sig_d=0, strobe_out=0.
//  Counter:
//  - on clk with en=1: cnt_nx = (cnt==DIV-1) ? 0 : cnt+1; cnt <= cnt_nx.
//  Wave:
//  - L = DIV - DIV/2 (ceil), H = DIV/2 (floor).
//  - with en=1: signal_out <= (cnt_nx >= L).
//  - low L cycles, then high H cycles, period exactly DIV; duty 50% for even DIV.
//  - odd DIV: low phase is the longer one, e.g. DIV=3 gives 2 low / 1 high.
//  - after rst release: first rise at the L-th clk edge, first fall at the DIV-th, then periodic.
//  Strobe:
//  - sig_d <= signal_out on every clk, regardless of en.
//  - strobe_out = signal_out & ~sig_d.
//  - asserted exactly during the first cycle signal_out is high; 0 extra latency relative to signal_out.
//  - one strobe per period, first at clk edge L after rst release.
//  Enable:
//  - en=0: cnt and signal_out hold.
//  - strobe_out still drops after one cycle (sig_d catches up); a frozen-high wave never re-strobes.
//  - en=1 resumes counting from the held cnt; the phase is preserved.
//  Boundaries:
//  - cnt wraps DIV-1 -> 0; the wrap cycle is the falling edge of signal_out.
//  - DIV=2: signal_out toggles every clk; strobe_out high every other cycle.
//  - rst mid-period: all outputs 0 at once (async), no strobe on release.
//  - The timing sequence restarts from cnt=0.
//  - No glitches: signal_out is a flop; strobe_out is a 2-input AND of flops.
// CONFIGURATION
//  FRQ_DIV_FALL_STROBE_EN
//  - defined: adds output strobe_fall (1 bit) = ~signal_out & sig_d.
//    One-clk pulse in the first low cycle after each 1->0 of signal_out; reset value 0.
//  - undefined: port and logic absent; all other behaviour identical.
// TESTING
//  DIV=20, en=1, release rst:
//  - signal_out 0 for edges 1..9, 1 from edge 10, 0 from edge 20.
//  - strobe_out high after edges 10, 30, 50 ... only.
//  DIV=30 and DIV=40, run 1 ms at 50 MHz:
//  - signal_out period 30/40 clk, duty exactly 15/15 and 20/20.
//  - strobe count = floor((cycles-L)/DIV)+1.
//  DIV=3:
//  - pattern 0,0,1 repeating; strobe_out coincides with every high cycle.
//  DIV=20, drop en for 7 cycles while signal_out=1:
//  - signal_out stays 1; strobe_out single pulse; period extended by exactly 7.
//  Assert rst asynchronously mid-high phase:
//  - signal_out/strobe_out go 0 before the next clk edge.
//  - After release, first strobe at edge 10 again.
//  With FRQ_DIV_FALL_STROBE_EN, DIV=20:
//  - strobe_fall high after edges 20, 40 ...; never coincident with strobe_out.

Source files
------------

// File: rtl/frq_div_mod_if.sv
// Enable/output bundle for frq_div_mod; strobe_fall is present only when
// FRQ_DIV_FALL_STROBE_EN is defined.
interface frq_div_mod_if;
  logic en;
  logic signal_out;
  logic strobe_out;
`ifdef FRQ_DIV_FALL_STROBE_EN
  logic strobe_fall;

  modport master (output en, input signal_out, input strobe_out, input strobe_fall);
  modport slave  (input en, output signal_out, output strobe_out, output strobe_fall);
`else
  modport master (output en, input signal_out, input strobe_out);
  modport slave  (input en, output signal_out, output strobe_out);
`endif
endinterface

// File: rtl/frq_div_mod.sv
// Integer clock divider: registered square wave plus one-clk rising-edge strobe.
// Optional falling-edge strobe enabled by defining FRQ_DIV_FALL_STROBE_EN.
module frq_div_mod #(
  parameter  int unsigned DIV   = 20,
  localparam int unsigned CNT_W = (DIV >= 2) ? $clog2(DIV) : 1
) (
  input  logic         clk,
  input  logic         rst,
  frq_div_mod_if.slave div_if
);

  localparam int unsigned LOW_CYC = DIV - DIV / 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LOW = CNT_W'(LOW_CYC);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("frq_div_mod: DIV must be >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             sig_q;
  logic             sig_d;

  always_comb begin
    cnt_nx = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
  end

  // sig_d tracks signal_out even while frozen so a held-high wave strobes only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      sig_q <= 1'b0;
      sig_d <= 1'b0;
    end else begin
      sig_d <= sig_q;
      if (div_if.en) begin
        cnt   <= cnt_nx;
        sig_q <= (cnt_nx >= CNT_LOW);
      end
    end
  end

  assign div_if.signal_out = sig_q;
  assign div_if.strobe_out = sig_q & ~sig_d;
`ifdef FRQ_DIV_FALL_STROBE_EN
  assign div_if.strobe_fall = ~sig_q & sig_d;
`endif

endmodule

// File: tb/tb_frq_div_mod.sv
// Self-checking bench for frq_div_mod: DIV=20/3/2 instances, table-driven start-up
// vectors, then scoreboard-checked enable-freeze and async-reset sequences.
module tb_frq_div_mod;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frq_div_mod_if if20 ();
  frq_div_mod_if if3 ();
  frq_div_mod_if if2 ();

  frq_div_mod #(.DIV(20)) u_div20 (.clk(clk), .rst(rst), .div_if(if20.slave));
  frq_div_mod #(.DIV(3))  u_div3  (.clk(clk), .rst(rst), .div_if(if3.slave));
  frq_div_mod #(.DIV(2))  u_div2  (.clk(clk), .rst(rst), .div_if(if2.slave));

  typedef struct {
    logic s20, b20, f20;
    logic s3, b3;
    logic s2, b2;
  } exp_t;

  typedef struct {
    logic en;
    exp_t exp;
  } vec_t;

  vec_t vecs[24];
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // Reference state: enabled-edge phase per instance and previous wave level.
  int   ph20 = 0, ph3 = 0, ph2 = 0;
  logic m_s20 = 1'b0, m_s3 = 1'b0, m_s2 = 1'b0;
  logic m_d20 = 1'b0, m_d3 = 1'b0, m_d2 = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic en_v, input logic rst_v, output exp_t m);
    @(negedge clk);
    if20.en = en_v;
    rst     = rst_v;
    if (rst_v) begin
      ph20 = 0; ph3 = 0; ph2 = 0;
      m_s20 = 1'b0; m_s3 = 1'b0; m_s2 = 1'b0;
      m_d20 = 1'b0; m_d3 = 1'b0; m_d2 = 1'b0;
    end else begin
      m_d20 = m_s20; m_d3 = m_s3; m_d2 = m_s2;
      if (en_v) begin
        ph20  = (ph20 + 1) % 20;
        m_s20 = (ph20 >= 10);
      end
      ph3  = (ph3 + 1) % 3;
      m_s3 = (ph3 >= 2);
      ph2  = (ph2 + 1) % 2;
      m_s2 = (ph2 >= 1);
    end
    m.s20 = m_s20; m.b20 = m_s20 & ~m_d20; m.f20 = ~m_s20 & m_d20;
    m.s3  = m_s3;  m.b3  = m_s3 & ~m_d3;
    m.s2  = m_s2;  m.b2  = m_s2 & ~m_d2;
  endtask

  task automatic sample();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty cycle %0d: got 0 entries expected 1", cyc);
    end else begin
      e = sb_q.pop_front();
      chk("signal_out_div20", if20.signal_out, e.s20);
      chk("strobe_out_div20", if20.strobe_out, e.b20);
      chk("signal_out_div3",  if3.signal_out,  e.s3);
      chk("strobe_out_div3",  if3.strobe_out,  e.b3);
      chk("signal_out_div2",  if2.signal_out,  e.s2);
      chk("strobe_out_div2",  if2.strobe_out,  e.b2);
`ifdef FRQ_DIV_FALL_STROBE_EN
      chk("strobe_fall_div20", if20.strobe_fall, e.f20);
      chk("fall_rise_overlap_div20", if20.strobe_fall & if20.strobe_out, 1'b0);
`endif
    end
  endtask

  task automatic step(input logic en_v, input logic rst_v);
    exp_t m;
    drive(en_v, rst_v, m);
    sb_q.push_back(m);
    sample();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t m;
    if20.en = 1'b1;
    if3.en  = 1'b1;
    if2.en  = 1'b1;

    // Start-up expectations after edge k = i+1 following reset release.
    for (int i = 0; i < 24; i++) begin
      int k;
      k = i + 1;
      vecs[i].en      = 1'b1;
      vecs[i].exp.s20 = (k >= 10) && (k < 20);
      vecs[i].exp.b20 = (k == 10);
      vecs[i].exp.f20 = (k == 20);
      vecs[i].exp.s3  = ((k % 3) == 2);
      vecs[i].exp.b3  = ((k % 3) == 2);
      vecs[i].exp.s2  = ((k % 2) == 1);
      vecs[i].exp.b2  = ((k % 2) == 1);
    end

    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].en, 1'b0, m);
      sb_q.push_back(vecs[i].exp);
      sample();
    end

    // Freeze DIV=20 for 7 cycles mid-high phase, then resume.
    for (int i = 0; i < 40 && ph20 != 12; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 45; i++) step(1'b1, 1'b0);

    // Asynchronous reset in the middle of the high phase.
    for (int i = 0; i < 40 && ph20 != 14; i++) step(1'b1, 1'b0);
    chk("pre_rst_high_div20", if20.signal_out, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_signal_div20", if20.signal_out, 1'b0);
    chk("async_rst_strobe_div20", if20.strobe_out, 1'b0);
    chk("async_rst_signal_div3",  if3.signal_out,  1'b0);
    chk("async_rst_signal_div2",  if2.signal_out,  1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
